dram_write_fifo: RTL

DRAM_WRITE_FIFO -- requirements
Module: dram_write_fifo

---
 rtl/dram_write_fifo.sv | 114 +++++++++++
 1 files changed

// File: rtl/dram_write_fifo.sv
// Four-entry write buffer between the sample packer and a DRAM controller app port.
// Each entry is issued as one single-beat write; command and data handshakes may complete in either order.
module dram_write_fifo #(
  parameter int MEM_IF_WIDTH = 128,
  parameter int ADX_WIDTH    = 27,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  input  logic [MEM_IF_WIDTH-1:0] wr_data,
  input  logic [ADX_WIDTH-1:0]    wr_adx,
  output logic                    write_allowed,
  output logic [2:0]              app_cmd,
  output logic [ADX_WIDTH-1:0]    app_addr,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [MEM_IF_WIDTH-1:0] app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy,
  output logic [DEPTH_LOG2:0]     level,
  output logic                    overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef struct packed {
    logic [ADX_WIDTH-1:0]    adx;
    logic [MEM_IF_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  entry_t                mem [DEPTH];
  entry_t                head;
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  cmd_done_q, cmd_done_d, data_done_q, data_done_d;
  logic                  overflow_q;
  logic                  push, pop, cmd_ok, data_ok;

  assign write_allowed = (level_q != FULL);
  assign push          = wr_req && write_allowed;
  assign app_en        = (state_q == ISSUE) && !cmd_done_q;
  assign app_wdf_wren  = (state_q == ISSUE) && !data_done_q;
  assign app_wdf_end   = app_wdf_wren;
  assign app_cmd       = 3'b000;
  assign cmd_ok        = cmd_done_q || (app_en && app_rdy);
  assign data_ok       = data_done_q || (app_wdf_wren && app_wdf_rdy);
  assign pop           = (state_q == ISSUE) && cmd_ok && data_ok;
  assign head          = mem[rptr_q];
  assign app_addr      = head.adx;
  assign app_wdf_data  = head.data;
  assign level         = level_q;
  assign overflow      = overflow_q;

  // Storage is intentionally unreset; outputs are qualified by app_en/app_wdf_wren.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= '{adx: wr_adx, data: wr_data};
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  // Leaving IDLE on the push edge itself gives app_en the cycle right after the push.
  always_comb begin
    state_d     = state_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    case (state_q)
      IDLE: begin
        cmd_done_d  = 1'b0;
        data_done_d = 1'b0;
        if (level_d != '0) state_d = ISSUE;
      end
      ISSUE: begin
        if (pop) begin
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          if (level_d == '0) state_d = IDLE;
        end else begin
          cmd_done_d  = cmd_ok;
          data_done_d = data_ok;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (wr_req && !write_allowed) overflow_q <= 1'b1;
    end
  end
endmodule
